// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator: a shared prescaler makes a BASE_HZ tick, and N_CH programmable dividers (periodic or one-shot) run off it.
// Optional macro TICKGEN_SYNC_EN adds a sync_clr input that clears the prescaler and the counters of running channels.
module tick_gen_multi #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BASE_HZ = 1_000,
  parameter int N_CH    = 4,
  parameter int DIV_W   = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
`ifdef TICKGEN_SYNC_EN
  input  logic                                       sync_clr,
`endif
  output logic                                       base_tick,
  input  logic                                       cfg_valid,
  output logic                                       cfg_ready,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]                           cfg_period,
  input  logic                                       cfg_mode,
  input  logic                                       cfg_start,
  output logic                                       cfg_err,
  output logic [N_CH-1:0]                            tick,
  output logic [N_CH-1:0]                            done,
  output logic [N_CH-1:0]                            running
);

  localparam int PRE  = CLK_HZ / BASE_HZ;
  localparam int PW   = (PRE >= 2) ? $clog2(PRE) : 1;
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W:0] N_CH_W = (CH_W + 1)'(N_CH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (CLK_HZ % BASE_HZ != 0) begin : g_chk_div
    $fatal(1, "tick_gen_multi: CLK_HZ must be a multiple of BASE_HZ");
  end
  if (PRE < 2) begin : g_chk_pre
    $fatal(1, "tick_gen_multi: CLK_HZ/BASE_HZ must be at least 2");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_chk_nch
    $fatal(1, "tick_gen_multi: N_CH must be 1..16");
  end
  if (DIV_W < 1) begin : g_chk_divw
    $fatal(1, "tick_gen_multi: DIV_W must be at least 1");
  end

  logic sync_c;
`ifdef TICKGEN_SYNC_EN
  assign sync_c = sync_clr;
`else
  assign sync_c = 1'b0;
`endif

  logic [PW-1:0] presc;
  logic          base_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      base_q <= 1'b0;
    end else if (sync_c) begin
      presc  <= '0;
      base_q <= 1'b0;
    end else if (presc == PW'(PRE - 1)) begin
      presc  <= '0;
      base_q <= 1'b1;
    end else begin
      presc  <= presc + 1'b1;
      base_q <= 1'b0;
    end
  end

  assign base_tick = base_q & ~sync_c;

  // cfg handshake: a transfer happens on any clk edge where cfg_valid && cfg_ready;
  // cfg_ready is high whenever rst is low, so a request is never held off.
  logic cfg_accept, cfg_bad, ch_oob, err_q;

  assign cfg_ready  = ~rst;
  assign cfg_accept = cfg_valid & cfg_ready;
  assign ch_oob     = ({1'b0, cfg_ch} >= N_CH_W);
  assign cfg_bad    = ch_oob | (cfg_start & (cfg_period == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= cfg_accept & cfg_bad;
  end

  assign cfg_err = err_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(g);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] per;
    logic [1:0]       st;
    logic             mode_q;
    logic             tick_q;
    logic             sel;

    assign sel = cfg_accept & ~cfg_bad & (cfg_ch == IDX);

    // A cfg aimed at this channel beats a coincident base tick, which is then not counted.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt    <= '0;
        per    <= '0;
        st     <= ST_IDLE;
        mode_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (sel) begin
          cnt <= '0;
          if (cfg_start) begin
            per    <= cfg_period;
            mode_q <= cfg_mode;
            st     <= ST_RUN;
          end else begin
            st <= ST_IDLE;
          end
        end else if (sync_c) begin
          if (st == ST_RUN) cnt <= '0;
        end else if (base_q && st == ST_RUN) begin
          if (cnt == per - 1'b1) begin
            cnt    <= '0;
            tick_q <= 1'b1;
            if (mode_q) st <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end

    assign tick[g]    = tick_q & ~sync_c;
    assign done[g]    = (st == ST_DONE);
    assign running[g] = (st == ST_RUN);
  end

endmodule
